mem_access_unit: RTL

//  Load/store sequencer directly upstream of DataMem (256x8, byte-select port). Accepts one

---
 rtl/mem_access_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Byte/word load-store sequencer in front of a 256x8 byte-lane DataMem.
// Words split into low byte at Addr and high byte at Addr+1.
module mem_access_unit #(
  parameter int AW       = 8,
  parameter bit SIGN_EXT = 1'b0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          IsStore,
  input  logic          Word,
  input  logic [AW-1:0] Addr,
  input  logic [15:0]   StoreData,
  output logic          Busy,
  output logic          Done,
  output logic [15:0]   LoadData,
  output logic          MemWrite,
  output logic          MemRead,
  output logic          Byte,
  output logic [AW-1:0] DataAddress,
  output logic [15:0]   DataIn,
  input  logic [15:0]   DataOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          op_store;
  logic          op_word;
  logic [AW-1:0] op_addr;
  logic [15:0]   op_data;
  logic [7:0]    lo_byte;
  logic [AW-1:0] hi_addr;

  // Address wraps naturally at the top of the byte space.
  assign hi_addr = op_addr + {{(AW-1){1'b0}}, 1'b1};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      op_store <= 1'b0;
      op_word  <= 1'b0;
      op_addr  <= '0;
      op_data  <= '0;
      lo_byte  <= '0;
      LoadData <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && Start) begin
        op_store <= IsStore;
        op_word  <= Word;
        op_addr  <= Addr;
        op_data  <= StoreData;
      end
      if (state == LO && !op_store) begin
        lo_byte <= DataOut[7:0];
        if (!op_word) begin
          LoadData <= {{8{SIGN_EXT & DataOut[7]}},
                       DataOut[7:0]};
        end
      end
      if (state == HI && !op_store) begin
        LoadData <= {DataOut[15:8], lo_byte};
      end
    end
  end

  always_comb begin
    state_nx    = state;
    Busy        = 1'b1;
    Done        = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    Byte        = 1'b0;
    DataAddress = '0;
    DataIn      = '0;
    unique case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Start) state_nx = LO;
      end
      LO: begin
        DataAddress = op_addr;
        MemWrite    = op_store;
        MemRead     = !op_store;
        if (op_store) DataIn = {8'h00, op_data[7:0]};
        state_nx = op_word ? HI : DONE;
      end
      HI: begin
        DataAddress = hi_addr;
        Byte        = 1'b1;
        MemWrite    = op_store;
        MemRead     = !op_store;
        if (op_store) DataIn = {op_data[15:8], 8'h00};
        state_nx = DONE;
      end
      DONE: begin
        Done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
